// File: rtl/mem_access_stage.sv
// MEM stage: byte-wide load/store over a req/ack bus with a bounded wait, upstream stall
// and the registered MEM/WB (p4) bundle.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_flush,
  input  logic        p3_memRead,
  input  logic        p3_memWrite,
  input  logic        p3_alu_regWrite,
  input  logic        p3_mem_regWrite,
  input  logic [2:0]  p3_alu_rd,
  input  logic [2:0]  p3_mem_rd,
  input  logic [7:0]  p3_mem_reg_rd,
  input  logic [31:0] p3_alu_aluOut,
  input  logic [31:0] p3_mem_address,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  output logic        mem_stall,
  output logic        p4_alu_regWrite,
  output logic        p4_mem_regWrite,
  output logic [2:0]  p4_alu_rd,
  output logic [2:0]  p4_mem_rd,
  output logic [31:0] p4_alu_aluOut,
  output logic [31:0] p4_mem_data,
  output logic        mem_fault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  // Last WAIT count before a forced completion; unused when TIMEOUT is 0.
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        fault_q, fault_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  data_q, data_d;
  logic        p4_alu_rw_q, p4_alu_rw_d;
  logic        p4_mem_rw_q, p4_mem_rw_d;
  logic [2:0]  p4_alu_rd_q, p4_alu_rd_d;
  logic [2:0]  p4_mem_rd_q, p4_mem_rd_d;
  logic [31:0] p4_alu_out_q, p4_alu_out_d;
  logic [31:0] p4_mem_data_q, p4_mem_data_d;
  logic        op;
  logic        load_p4;

  assign op = p3_memRead | p3_memWrite;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    fault_d = fault_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    load_p4 = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          req_d   = 1'b1;
          we_d    = p3_memWrite;
          addr_d  = p3_mem_address;
          wdata_d = p3_mem_reg_rd;
          cnt_d   = 8'd0;
          kill_d  = MEM_flush;
          state_d = WAIT;
        end else begin
          load_p4 = ~MEM_flush;
        end
      end
      WAIT: begin
        if (MEM_flush) kill_d = 1'b1;
        if (dmem_ack) begin
          data_d  = we_q ? 8'd0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          data_d  = 8'd0;
          req_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        load_p4 = ~(kill_q | MEM_flush);
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p4 takes the p3 bundle only when the instruction retires from MEM; otherwise a zeroed bubble.
  always_comb begin
    p4_alu_rw_d   = 1'b0;
    p4_mem_rw_d   = 1'b0;
    p4_alu_rd_d   = 3'd0;
    p4_mem_rd_d   = 3'd0;
    p4_alu_out_d  = 32'd0;
    p4_mem_data_d = 32'd0;
    if (load_p4) begin
      p4_alu_rw_d   = p3_alu_regWrite;
      p4_mem_rw_d   = p3_mem_regWrite;
      p4_alu_rd_d   = p3_alu_rd;
      p4_mem_rd_d   = p3_mem_rd;
      p4_alu_out_d  = p3_alu_aluOut;
      p4_mem_data_d = (state_q == RESP) ? {24'd0, data_q} : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      kill_q        <= 1'b0;
      fault_q       <= 1'b0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 8'd0;
      data_q        <= 8'd0;
      p4_alu_rw_q   <= 1'b0;
      p4_mem_rw_q   <= 1'b0;
      p4_alu_rd_q   <= 3'd0;
      p4_mem_rd_q   <= 3'd0;
      p4_alu_out_q  <= 32'd0;
      p4_mem_data_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kill_q        <= kill_d;
      fault_q       <= fault_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_q        <= data_d;
      p4_alu_rw_q   <= p4_alu_rw_d;
      p4_mem_rw_q   <= p4_mem_rw_d;
      p4_alu_rd_q   <= p4_alu_rd_d;
      p4_mem_rd_q   <= p4_mem_rd_d;
      p4_alu_out_q  <= p4_alu_out_d;
      p4_mem_data_q <= p4_mem_data_d;
    end
  end

  assign mem_stall       = (state_q == WAIT) || (state_q == IDLE && op);
  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign mem_fault       = fault_q;
  assign p4_alu_regWrite = p4_alu_rw_q;
  assign p4_mem_regWrite = p4_mem_rw_q;
  assign p4_alu_rd       = p4_alu_rd_q;
  assign p4_mem_rd       = p4_mem_rd_q;
  assign p4_alu_aluOut   = p4_alu_out_q;
  assign p4_mem_data     = p4_mem_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: each instruction pushes its expected p4 bundle,
// which is popped and compared on the edge that retires it; a behavioural memory answers requests.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MEM_flush = 1'b0;
  logic        p3_memRead = 1'b0, p3_memWrite = 1'b0;
  logic        p3_alu_regWrite = 1'b0, p3_mem_regWrite = 1'b0;
  logic [2:0]  p3_alu_rd = 3'd0, p3_mem_rd = 3'd0;
  logic [7:0]  p3_mem_reg_rd = 8'd0;
  logic [31:0] p3_alu_aluOut = 32'd0, p3_mem_address = 32'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [7:0]  dmem_rdata = 8'd0;
  logic        mem_stall;
  logic        p4_alu_regWrite, p4_mem_regWrite;
  logic [2:0]  p4_alu_rd, p4_mem_rd;
  logic [31:0] p4_alu_aluOut, p4_mem_data;
  logic        mem_fault;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MEM_flush(MEM_flush),
    .p3_memRead(p3_memRead), .p3_memWrite(p3_memWrite),
    .p3_alu_regWrite(p3_alu_regWrite), .p3_mem_regWrite(p3_mem_regWrite),
    .p3_alu_rd(p3_alu_rd), .p3_mem_rd(p3_mem_rd), .p3_mem_reg_rd(p3_mem_reg_rd),
    .p3_alu_aluOut(p3_alu_aluOut), .p3_mem_address(p3_mem_address),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .p4_alu_regWrite(p4_alu_regWrite), .p4_mem_regWrite(p4_mem_regWrite),
    .p4_alu_rd(p4_alu_rd), .p4_mem_rd(p4_mem_rd),
    .p4_alu_aluOut(p4_alu_aluOut), .p4_mem_data(p4_mem_data), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arw, mrw;
    logic [2:0]  ard, mrd;
    logic [31:0] alu, mdata;
    logic        bubble;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic fault_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the edge that moves the instruction into p4.
  // ack_delay: request cycle index carrying the ack (-1 = never). flush_cyc: cycle to pulse MEM_flush (-1 = none).
  task automatic run_instr(input string name, input logic mr, input logic mw,
                           input logic arw, input logic mrw, input logic [2:0] ard,
                           input logic [2:0] mrd, input logic [7:0] wd,
                           input logic [31:0] alu_out, input logic [31:0] addr,
                           input int ack_delay, input logic [7:0] rdata,
                           input int flush_cyc, input logic stray);
    exp_t e;
    logic op, st, ack, done;
    int   exp_stall, exp_req, stalls, req_cnt;
    op = mr | mw;
    exp_stall = !op ? 0 : (ack_delay < 0 ? 1 + TO : 2 + ack_delay);
    exp_req   = !op ? 0 : (ack_delay < 0 ? TO : ack_delay + 1);
    if (op && ack_delay < 0) fault_exp = 1'b1;
    e.bubble = (flush_cyc >= 0 && flush_cyc <= exp_stall);
    e.arw = arw; e.mrw = mrw; e.ard = ard; e.mrd = mrd; e.alu = alu_out;
    e.mdata = (op && !mw && ack_delay >= 0) ? {24'd0, rdata} : 32'd0;

    p3_memRead = mr; p3_memWrite = mw; p3_alu_regWrite = arw; p3_mem_regWrite = mrw;
    p3_alu_rd = ard; p3_mem_rd = mrd; p3_mem_reg_rd = wd;
    p3_alu_aluOut = alu_out; p3_mem_address = addr;
    sb_q.push_back(e);

    stalls = 0; req_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      st = mem_stall;
      if (st) stalls++;
      if (dmem_req) begin
        check({name, ".addr"}, dmem_addr, addr);
        check({name, ".we"}, {31'd0, dmem_we}, {31'd0, mw});
        check({name, ".wdata"}, {24'd0, dmem_wdata}, {24'd0, wd});
        ack = (req_cnt == ack_delay);
        req_cnt++;
      end else begin
        ack = stray && (cyc == 0);
      end
      dmem_ack   = ack;
      dmem_rdata = ack ? rdata : 8'($urandom);
      MEM_flush  = (cyc == flush_cyc);
      @(negedge clk);
      if (!st) begin
        done = 1'b1;
        break;
      end
    end
    dmem_ack = 1'b0;
    MEM_flush = 1'b0;

    check({name, ".done"}, {31'd0, done}, 32'd1);
    check({name, ".stalls"}, stalls, exp_stall);
    check({name, ".req_cycles"}, req_cnt, exp_req);
    check({name, ".req_low"}, {31'd0, dmem_req}, 32'd0);
    check({name, ".fault"}, {31'd0, mem_fault}, {31'd0, fault_exp});
    e = sb_q.pop_front();
    check({name, ".alu_rw"}, {31'd0, p4_alu_regWrite}, {31'd0, e.arw & ~e.bubble});
    check({name, ".mem_rw"}, {31'd0, p4_mem_regWrite}, {31'd0, e.mrw & ~e.bubble});
    if (!e.bubble) begin
      check({name, ".alu_rd"}, {29'd0, p4_alu_rd}, {29'd0, e.ard});
      check({name, ".mem_rd"}, {29'd0, p4_mem_rd}, {29'd0, e.mrd});
      check({name, ".aluOut"}, p4_alu_aluOut, e.alu);
      check({name, ".mem_data"}, p4_mem_data, e.mdata);
    end
    $display("[TB] %s: stalls=%0d req_cycles=%0d p4_aluOut=0x%0h p4_mem_data=0x%0h fault=%0b",
             name, stalls, req_cnt, p4_alu_aluOut, p4_mem_data, mem_fault);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req", {31'd0, dmem_req}, 32'd0);
    check("rst.stall", {31'd0, mem_stall}, 32'd0);
    check("rst.fault", {31'd0, mem_fault}, 32'd0);
    check("rst.p4", {p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd} | p4_alu_aluOut | p4_mem_data, 32'd0);
    reset = 1'b0;

    run_instr("alu1", 0, 0, 1, 0, 3'd1, 3'd0, 8'h00, 32'h11, 32'h0, -1, 8'h00, -1, 0);
    run_instr("alu2", 0, 0, 1, 0, 3'd2, 3'd0, 8'h00, 32'h22, 32'h0, -1, 8'h00, -1, 0);
    run_instr("alu3", 0, 0, 1, 0, 3'd3, 3'd0, 8'h00, 32'h33, 32'h0, -1, 8'h00, -1, 0);
    run_instr("load", 1, 0, 0, 1, 3'd0, 3'd4, 8'h00, 32'h0, 32'h40, 0, 8'hA5, -1, 0);
    run_instr("load_b2b", 1, 0, 0, 1, 3'd0, 3'd5, 8'h00, 32'h0, 32'h41, 1, 8'h3C, -1, 0);
    run_instr("store", 0, 1, 0, 0, 3'd0, 3'd0, 8'h5C, 32'h0, 32'h80, 2, 8'hEE, -1, 0);
    run_instr("rdwr", 1, 1, 0, 0, 3'd0, 3'd0, 8'h77, 32'h0, 32'h90, 0, 8'hEE, -1, 0);
    run_instr("alu_flush", 0, 0, 1, 0, 3'd6, 3'd0, 8'h00, 32'h66, 32'h0, -1, 8'h00, 0, 0);
    run_instr("load_flush", 1, 0, 0, 1, 3'd0, 3'd2, 8'h00, 32'h0, 32'h50, 2, 8'h99, 1, 0);
    run_instr("alu_after", 0, 0, 1, 0, 3'd7, 3'd0, 8'h00, 32'h77, 32'h0, -1, 8'h00, -1, 0);
    run_instr("timeout", 1, 0, 0, 1, 3'd0, 3'd1, 8'h00, 32'h0, 32'hC0, -1, 8'h00, -1, 0);
    run_instr("stray_ack", 0, 0, 1, 0, 3'd4, 3'd0, 8'h00, 32'h44, 32'h0, -1, 8'hFF, -1, 1);

    // Reset while waiting on the bus; upstream registers clear with it, so p3 goes to zero too.
    p3_memRead = 1'b1; p3_memWrite = 1'b0; p3_mem_regWrite = 1'b1; p3_mem_rd = 3'd3;
    p3_alu_regWrite = 1'b0; p3_mem_address = 32'h44;
    @(negedge clk);
    #1;
    check("rstw.req_before", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    p3_memRead = 1'b0; p3_mem_regWrite = 1'b0; p3_mem_rd = 3'd0; p3_mem_address = 32'h0;
    @(negedge clk);
    fault_exp = 1'b0;
    check("rstw.req", {31'd0, dmem_req}, 32'd0);
    check("rstw.stall", {31'd0, mem_stall}, 32'd0);
    check("rstw.fault", {31'd0, mem_fault}, 32'd0);
    check("rstw.p4", {p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd} | p4_alu_aluOut | p4_mem_data, 32'd0);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 8'hAB;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("rstw.late_ack_req", {31'd0, dmem_req}, 32'd0);
    check("rstw.late_ack_stall", {31'd0, mem_stall}, 32'd0);
    $display("[TB] reset_in_wait: req=%0b stall=%0b fault=%0b", dmem_req, mem_stall, mem_fault);
    run_instr("alu_post_rst", 0, 0, 1, 0, 3'd5, 3'd0, 8'h00, 32'h55, 32'h0, -1, 8'h00, -1, 0);
    run_instr("load_post_rst", 1, 0, 0, 1, 3'd0, 3'd6, 8'h00, 32'h0, 32'h48, 0, 8'h5A, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
